dir_input_ctrl: RTL and testbench

- Front-end stage that produces the `dir` and `game_started` inputs consumed by the snake engine/VGA top level.
- Turns four raw active-low push buttons into a legal direction stream:
  - synchronises and debounces the buttons;
  - rejects 180° reversals and no-op turns;
  - buffers turns made between steps in a small queue, committing exactly one turn per snake step.
- Owns the IDLE/RUN/OVER game-start state machine.

---
 rtl/snake_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 62 ++++++
 rtl/dir_input_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dir_input_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake front-end.
//   - DIR_* : 2-bit direction encoding (also the button index order)
//   - reverse() : opposite direction (flip bit 1)
//   - ctrl_state_t : game-start state machine encoding
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } ctrl_state_t;

    function automatic logic [1:0] reverse(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchroniser, stability counter, press pulse.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   btn_n_i       : raw button, active low
//   press_o       : one-cycle pulse on an accepted release->press flip
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;

    // The synchroniser resets to "pressed" and a press only counts once a
    // debounced release has been seen, so a button held through reset
    // never produces a press until it is released and pressed again.
    always_comb begin
        db_d    = db_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        armed_d = armed_q | (~db_q & ~s2_q);
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_d    = s2_q;
            cnt_d   = '0;
            press_d = s2_q & armed_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= ~btn_n_i;
            s2_q    <= s1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/dir_input_ctrl.sv
// Button front-end for the snake engine: debounces four buttons, filters
// reversals/no-op turns, buffers pending turns and commits one per step,
// and runs the IDLE/RUN/OVER game-start FSM.
// Build option: define TURN_QUEUE_EN for a QUEUE_DEPTH-entry turn FIFO;
// otherwise a single latest-wins pending-turn register is used.
// Ports:
//   CLOCK_50, resetn : clock, async active-low reset
//   btn_n[3:0]       : raw buttons, active low (up, right, down, left)
//   step             : one-cycle snake step pulse
//   game_over        : level from the engine
//   dir              : committed direction
//   game_started     : high in RUN or OVER
//   queue_count      : pending turns
//   dropped          : one-cycle pulse when a press is discarded
module dir_input_ctrl
    import snake_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         QUEUE_DEPTH     = 2,
    parameter logic [1:0] INIT_DIR        = 2'b01
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] btn_n,
    input  logic       step,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       game_started,
    output logic [1:0] queue_count,
    output logic       dropped
);

    logic [3:0] press;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i  (CLOCK_50),
            .rst_ni (resetn),
            .btn_n_i(btn_n[i]),
            .press_o(press[i])
        );
    end

    // Button index equals direction code, so the winner index is the turn.
    logic       any_press, multi_press;
    logic [1:0] win_dir;
    always_comb begin
        any_press   = |press;
        multi_press = (press & (press - 4'd1)) != 4'd0;
        if (press[0])      win_dir = DIR_UP;
        else if (press[1]) win_dir = DIR_RIGHT;
        else if (press[2]) win_dir = DIR_DOWN;
        else               win_dir = DIR_LEFT;
    end

    ctrl_state_t state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic        dropped_q, dropped_d;
    logic        push, pop, flush;
    logic        q_nonempty, can_push;
    logic [1:0]  head_dir, ref_dir;

`ifdef TURN_QUEUE_EN
    // Storage is sized for the largest legal depth so 2-bit pointers index
    // it exactly; pointers wrap at QUEUE_DEPTH.
    logic [3:0][1:0] fifo_q;
    logic [1:0]      rd_q, wr_q, cnt_q, last_idx;

    function automatic logic [1:0] inc(input logic [1:0] p);
        return (p == 2'(QUEUE_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign last_idx   = (wr_q == 2'd0) ? 2'(QUEUE_DEPTH - 1) : wr_q - 2'd1;
    assign q_nonempty = cnt_q != 2'd0;
    assign head_dir   = fifo_q[rd_q];
    assign ref_dir    = q_nonempty ? fifo_q[last_idx] : dir_q;
    // A full queue still takes a push when the same cycle pops.
    assign can_push   = (cnt_q != 2'(QUEUE_DEPTH)) | pop;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            fifo_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= win_dir;
                wr_q         <= inc(wr_q);
            end
            if (pop) rd_q <= inc(rd_q);
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    assign queue_count = cnt_q;
`else
    logic [1:0] pend_q;
    logic       pend_vld_q;

    assign q_nonempty = pend_vld_q;
    assign head_dir   = pend_q;
    assign ref_dir    = dir_q;
    // Latest-wins: the single slot always takes a legal press.
    assign can_push   = (QUEUE_DEPTH > 0);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else if (flush) begin
            pend_vld_q <= 1'b0;
        end else if (push) begin
            pend_q     <= win_dir;
            pend_vld_q <= 1'b1;
        end else if (pop) begin
            pend_vld_q <= 1'b0;
        end
    end

    assign queue_count = {1'b0, pend_vld_q};
`endif

    logic legal;
    assign legal = (win_dir != ref_dir) && (win_dir != reverse(ref_dir));

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        dropped_d = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_press) begin
                    dir_d     = win_dir;
                    state_d   = RUN;
                    dropped_d = multi_press;
                end
            end
            RUN: begin
                // game_over wins over step: flush, no pop.
                if (game_over) begin
                    state_d = OVER;
                    flush   = 1'b1;
                end else begin
                    pop = step & q_nonempty;
                    if (pop) dir_d = head_dir;
                    if (any_press) begin
                        if (legal && can_push) push = 1'b1;
                        else                   dropped_d = 1'b1;
                        if (multi_press) dropped_d = 1'b1;
                    end
                end
            end
            OVER:    ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            dir_q     <= INIT_DIR;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            dropped_q <= dropped_d;
        end
    end

    assign dir          = dir_q;
    assign dropped      = dropped_q;
    assign game_started = (state_q != IDLE);

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Scoreboard bench for dir_input_ctrl with DEBOUNCE_CYCLES=4, depth 2.
// Any change of dir/game_started/queue_count, or a dropped pulse, is an
// output event; the monitor pops the expected snapshot for each one.
module tb_dir_input_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] btn_n;
    logic       step, game_over;
    logic [1:0] dir, queue_count;
    logic       game_started, dropped;

    dir_input_ctrl #(.DEBOUNCE_CYCLES(4), .QUEUE_DEPTH(2), .INIT_DIR(2'b01)) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .btn_n       (btn_n),
        .step        (step),
        .game_over   (game_over),
        .dir         (dir),
        .game_started(game_started),
        .queue_count (queue_count),
        .dropped     (dropped)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [1:0] d;
        logic       gs;
        logic [1:0] qc;
        logic       dr;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    started = 1'b0;

    task automatic expect_ev(input logic [1:0] d, input logic gs, input logic [1:0] qc, input logic dr);
        snap_t s;
        s.d = d; s.gs = gs; s.qc = qc; s.dr = dr;
        exp_q.push_back(s);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        btn_n = btn_n & ~mask;
        tick(12);
        btn_n = btn_n | mask;
        tick(12);
    endtask

    // Press so the debounced event lands in the same cycle as step.
    task automatic press_step(input logic [3:0] mask);
        btn_n = btn_n & ~mask;
        tick(6);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(6);
        btn_n = btn_n | mask;
        tick(12);
    endtask

    task automatic do_step();
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(3);
    endtask

    // Monitor
    initial begin
        logic [1:0] ld, lq;
        logic       lg;
        snap_t      e;
        ld = 2'b01; lq = 2'b00; lg = 1'b0;
        forever begin
            @(negedge clk);
            if (started && resetn && (dropped || dir != ld || queue_count != lq || game_started != lg)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got dir=%0d gs=%0d qc=%0d drop=%0d, none expected",
                             dir, game_started, queue_count, dropped);
                end else begin
                    e = exp_q.pop_front();
                    if (e.d != dir || e.gs != game_started || e.qc != queue_count || e.dr != dropped) begin
                        errors++;
                        $display("FAIL event: got dir=%0d gs=%0d qc=%0d drop=%0d, expected dir=%0d gs=%0d qc=%0d drop=%0d",
                                 dir, game_started, queue_count, dropped, e.d, e.gs, e.qc, e.dr);
                    end
                end
            end
            ld = dir; lq = queue_count; lg = game_started;
        end
    end

    initial begin
        resetn = 1'b0; btn_n = 4'hF; step = 1'b0; game_over = 1'b0;
        tick(3);
        chk("rst_dir", dir, 1);
        chk("rst_gs", game_started, 0);
        chk("rst_qc", queue_count, 0);
        chk("rst_drop", dropped, 0);
        resetn = 1'b1;
        started = 1'b1;
        tick(50);
        chk("idle_dir", dir, 1);
        chk("idle_gs", game_started, 0);
        chk("idle_qc", queue_count, 0);

        // IDLE: clean press down, check latency edge by edge
        expect_ev(2'b10, 1, 0, 0);
        btn_n[2] = 1'b0;
        tick(6);
        chk("lat_dir_before", dir, 1);
        chk("lat_gs_before", game_started, 0);
        tick(1);
        chk("lat_dir_after", dir, 2);
        chk("lat_gs_after", game_started, 1);
        tick(5);
        btn_n[2] = 1'b1;
        tick(12);

        // Bounce train on right: exactly one event (a second would drop)
        expect_ev(2'b10, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            btn_n[1] = i[0];
            tick(1);
        end
        btn_n[1] = 1'b0;
        tick(12);
        btn_n[1] = 1'b1;
        tick(12);
        expect_ev(2'b01, 1, 0, 0);
        do_step();

        // Reversal vs dir=right
        expect_ev(2'b01, 1, 0, 1);
        press(4'b1000);
        // Simultaneous up+down: up wins and queues, down drops
        expect_ev(2'b01, 1, 1, 1);
        press(4'b0101);
`ifdef TURN_QUEUE_EN
        expect_ev(2'b01, 1, 2, 0);          // left vs tail up: legal
        press(4'b1000);
        expect_ev(2'b00, 1, 1, 0);
        do_step();
        expect_ev(2'b11, 1, 0, 0);
        do_step();
        // Fill, then push during a pop while full, then push while full
        expect_ev(2'b11, 1, 1, 0);
        press(4'b0001);
        expect_ev(2'b11, 1, 2, 0);
        press(4'b0010);
        expect_ev(2'b00, 1, 2, 0);
        press_step(4'b0100);
        expect_ev(2'b00, 1, 2, 1);
        press(4'b1000);
`else
        expect_ev(2'b01, 1, 1, 1);          // left vs dir right: reversal
        press(4'b1000);
        expect_ev(2'b00, 1, 0, 0);
        do_step();
        do_step();                          // nothing pending: dir holds
        chk("hold_dir", dir, 0);
        expect_ev(2'b00, 1, 1, 0);
        press(4'b0010);
        press(4'b1000);                     // overwrites pending silently
        expect_ev(2'b11, 1, 0, 1);          // down vs dir up drops; left commits
        press_step(4'b0100);
`endif

        // Reset while a button is held and turns are pending
        btn_n[0] = 1'b0;
        tick(3);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        chk("rst2_dir", dir, 1);
        chk("rst2_gs", game_started, 0);
        chk("rst2_qc", queue_count, 0);
        tick(30);
        chk("held_gs", game_started, 0);
        btn_n[0] = 1'b1;
        tick(12);
        expect_ev(2'b00, 1, 0, 0);
        press(4'b0001);

        expect_ev(2'b00, 1, 1, 0);
        press(4'b0010);
`ifdef TURN_QUEUE_EN
        expect_ev(2'b00, 1, 2, 0);
`else
        expect_ev(2'b00, 1, 1, 1);
`endif
        press(4'b0100);

        // game_over with step: flush, no pop, then presses are ignored
        expect_ev(2'b00, 1, 0, 0);
        game_over = 1'b1;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(3);
        press(4'b1000);
        press(4'b0010);
        do_step();
        chk("over_dir", dir, 0);
        chk("over_gs", game_started, 1);
        chk("over_qc", queue_count, 0);

        tick(5);
        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
